// File: rtl/protocol_encoder.sv
// protocol_encoder: host-side UART command initiator.
// Serialises NOP/WR/RD/LOAD and collects the single RD response byte.
module protocol_encoder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 4096,
  parameter int RSP_TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_type_i,
  input  logic [7:0]            cmd_addr_i,
  input  logic [7:0]            cmd_data_i,
  output logic                  tx_wr_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_done_i,
  input  logic                  rx_done_i,
  input  logic [7:0]            rx_data_i,
  output logic [ADDR_WIDTH-1:0] wave_rd_addr_o,
  input  logic [7:0]            wave_rd_data_i,
  output logic                  rsp_valid_o,
  output logic [7:0]            rsp_data_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o
);

  localparam int TW = $clog2(RSP_TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [TW-1:0] LAST_CNT =
    TW'(RSP_TIMEOUT - 1);

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_RD   = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    TX_BYTE,
    TX_WAIT,
    FETCH,
    LOAD_BYTE,
    RSP_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              type_q, type_d;
  logic [7:0]              addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic [1:0]              idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   pay_q, pay_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic [7:0]              rsp_data_q, rsp_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_tmo_q, rsp_tmo_d;
  logic [1:0]              last_idx;

  // NOP is a single byte; WR and RD are three
  assign last_idx = (type_q == OP_NOP) ? 2'd0 : 2'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      type_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      pay_q       <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      pay_q       <= pay_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    data_d      = data_q;
    idx_d       = idx_q;
    pay_d       = pay_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pay_d = '0;
        if (cmd_valid_i) begin
          type_d    = cmd_type_i;
          addr_d    = cmd_addr_i;
          data_d    = cmd_data_i;
          tx_data_d = {6'b0, cmd_type_i};
          idx_d     = 2'd0;
          state_d   = TX_BYTE;
        end
      end
      TX_BYTE: state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_done_i) begin
          if (type_q == OP_LOAD) begin
            if (idx_q == 2'd0) begin
              idx_d   = 2'd1;
              state_d = FETCH;
            end else if (pay_q == LAST_IDX) begin
              pay_d   = '0;
              state_d = IDLE;
            end else begin
              pay_d   = pay_q + 1'b1;
              state_d = FETCH;
            end
          end else if (idx_q != last_idx) begin
            idx_d   = idx_q + 2'd1;
            state_d = LOAD_BYTE;
          end else if (type_q == OP_RD) begin
            cnt_d   = '0;
            state_d = RSP_WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      // ROM address presented here; data returns next cycle
      FETCH: state_d = LOAD_BYTE;
      LOAD_BYTE: begin
        state_d = TX_BYTE;
        if (type_q == OP_LOAD) begin
          tx_data_d = wave_rd_data_i;
        end else if (idx_q == 2'd1) begin
          tx_data_d = addr_q;
        end else if (type_q == OP_WR) begin
          tx_data_d = data_q;
        end else begin
          tx_data_d = 8'h00;
        end
      end
      RSP_WAIT: begin
        if (rx_done_i) begin
          rsp_data_d  = rx_data_i;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          rsp_tmo_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign tx_wr_o        = (state_q == TX_BYTE);
  assign tx_data_o      = tx_data_q;
  assign wave_rd_addr_o = pay_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_timeout_o  = rsp_tmo_q;

endmodule

// File: tb/tb_protocol_encoder.sv
// tb_protocol_encoder: scoreboard bench for protocol_encoder.
// Byte/response expectations come from a command-level model.
module tb_protocol_encoder;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_type_i;
  logic [7:0]    cmd_addr_i;
  logic [7:0]    cmd_data_i;
  logic          tx_wr_o;
  logic [7:0]    tx_data_o;
  logic          tx_done_i;
  logic          rx_done_i;
  logic [7:0]    rx_data_i;
  logic [AW-1:0] wave_rd_addr_o;
  logic [7:0]    rom_q;
  logic          rsp_valid_o;
  logic [7:0]    rsp_data_o;
  logic          rsp_timeout_o;
  logic          busy_o;

  protocol_encoder #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RSP_TIMEOUT(TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_type_i    (cmd_type_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_data_i    (cmd_data_i),
    .tx_wr_o       (tx_wr_o),
    .tx_data_o     (tx_data_o),
    .tx_done_i     (tx_done_i),
    .rx_done_i     (rx_done_i),
    .rx_data_i     (rx_data_i),
    .wave_rd_addr_o(wave_rd_addr_o),
    .wave_rd_data_i(rom_q),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_timeout_o (rsp_timeout_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         gap;
    int         addr;
  } tx_exp_t;

  typedef struct {
    bit         tmo;
    logic [7:0] d;
    int         cyc;
  } rsp_exp_t;

  tx_exp_t    exp_tx[$];
  rsp_exp_t   exp_rsp[$];
  logic [7:0] rom[DEPTH];
  logic [7:0] last_rsp;
  int         cyc = 0;
  int         ref_cyc = 0;
  int         done_cnt = 0;
  int         fixed_delay = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         prev_wr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= rom[wave_rd_addr_o];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // UART transmitter model: done pulse some cycles after each write
  initial begin
    tx_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_wr_o) begin
        int d;
        d = (fixed_delay != 0) ? fixed_delay : $urandom_range(1, 6);
        repeat (d) @(posedge clk);
        #1;
        tx_done_i = 1'b1;
        ref_cyc   = cyc;
        done_cnt++;
        @(posedge clk);
        #1;
        tx_done_i = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT emits something
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("busy_vs_ready", 32'(busy_o), 32'(!cmd_ready_o));
        if (tx_wr_o) begin
          chk("tx_wr_width", 32'(prev_wr), 0);
          if (exp_tx.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected: got byte %h, expected none",
                     tx_data_o);
          end else begin
            tx_exp_t e;
            e = exp_tx.pop_front();
            chk("tx_data", tx_data_o, e.b);
            chk("tx_gap", cyc - ref_cyc, e.gap);
            chk("wave_addr", wave_rd_addr_o, e.addr);
          end
        end
        if (rsp_valid_o || rsp_timeout_o) begin
          if (exp_rsp.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_unexpected: got v=%b t=%b, expected none",
                     rsp_valid_o, rsp_timeout_o);
          end else begin
            rsp_exp_t r;
            r = exp_rsp.pop_front();
            chk("rsp_timeout", rsp_timeout_o, r.tmo);
            chk("rsp_valid", rsp_valid_o, !r.tmo);
            chk("rsp_data", rsp_data_o, r.d);
            chk("rsp_cycle", cyc, r.cyc);
          end
        end
        prev_wr = tx_wr_o;
      end else begin
        prev_wr = 1'b0;
      end
    end
  end

  // Reference model: wire bytes of one command
  task automatic push_cmd(input logic [1:0] t,
                          input logic [7:0] a,
                          input logic [7:0] d);
    exp_tx.push_back('{b: {6'b0, t}, gap: 1, addr: 0});
    case (t)
      2'd1: begin
        exp_tx.push_back('{b: a, gap: 2, addr: 0});
        exp_tx.push_back('{b: d, gap: 2, addr: 0});
      end
      2'd2: begin
        exp_tx.push_back('{b: a, gap: 2, addr: 0});
        exp_tx.push_back('{b: 8'h00, gap: 2, addr: 0});
      end
      2'd3: begin
        for (int i = 0; i < DEPTH; i++)
          exp_tx.push_back('{b: rom[i], gap: 3, addr: i});
      end
      default: ;
    endcase
  endtask

  task automatic send_cmd(input logic [1:0] t,
                          input logic [7:0] a,
                          input logic [7:0] d,
                          input bit         b2b);
    bit got;
    got = 1'b0;
    push_cmd(t, a, d);
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    cmd_valid_i = 1'b1;
    cmd_type_i  = t;
    cmd_addr_i  = a;
    cmd_data_i  = d;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        got     = 1'b1;
        ref_cyc = cyc;
        break;
      end
    end
    if (!got) chk("cmd_accept", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    cmd_type_i  = 2'($urandom);
    cmd_addr_i  = 8'($urandom);
    cmd_data_i  = 8'($urandom);
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_tx_done", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready_o && exp_tx.size() == 0 &&
          exp_rsp.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_idle", 32'(ok), 1);
    chk("idle_wave_addr", wave_rd_addr_o, 0);
  endtask

  // k: cycles from last tx_done to rx_done; 0 = far end silent
  task automatic rd_cmd(input logic [7:0] a,
                        input int k,
                        input logic [7:0] rdat);
    int base;
    int t;
    base = done_cnt;
    send_cmd(2'd2, a, 8'h00, 1'b0);
    wait_done(base + 3);
    t = ref_cyc;
    if (k >= 1 && k <= TMO) begin
      exp_rsp.push_back('{tmo: 1'b0, d: rdat, cyc: t + k + 1});
      last_rsp = rdat;
    end else begin
      exp_rsp.push_back('{tmo: 1'b1, d: last_rsp, cyc: t + 1 + TMO});
    end
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
      rx_done_i = 1'b1;
      rx_data_i = rdat;
      @(posedge clk);
      #1;
      rx_done_i = 1'b0;
    end
    wait_idle();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, cmd_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_tx_wr"}, tx_wr_o, 0);
    chk({tag, "_tx_data"}, tx_data_o, 0);
    chk({tag, "_wave_addr"}, wave_rd_addr_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_data"}, rsp_data_o, 0);
    chk({tag, "_rsp_tmo"}, rsp_timeout_o, 0);
  endtask

  initial begin
    int base;
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_type_i  = '0;
    cmd_addr_i  = '0;
    cmd_data_i  = '0;
    rx_done_i   = 1'b0;
    rx_data_i   = '0;
    last_rsp    = 8'h00;
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'(8'hF0 + i);

    repeat (2) @(negedge clk);
    check_reset("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // WR with fixed UART latency
    fixed_delay = 5;
    send_cmd(2'd1, 8'h12, 8'hA5, 1'b0);
    wait_idle();

    // RD answered 10 cycles after last tx_done
    rd_cmd(8'h07, 10, 8'h3C);
    fixed_delay = 0;

    // RD with no answer, then answers on the expiry edge and after it
    rd_cmd(8'h44, 0, 8'h00);
    rd_cmd(8'h45, TMO, 8'h9A);
    rd_cmd(8'h46, TMO + 1, 8'h5B);
    rd_cmd(8'h47, 1, 8'hC3);

    // LOAD full waveform
    send_cmd(2'd3, 8'h00, 8'h00, 1'b0);
    wait_idle();

    // NOP with WR held behind it
    send_cmd(2'd0, 8'h00, 8'h00, 1'b0);
    send_cmd(2'd1, 8'h33, 8'h66, 1'b1);
    wait_idle();

    // Stray handshakes while idle
    @(posedge clk);
    #1;
    tx_done_i = 1'b1;
    rx_done_i = 1'b1;
    rx_data_i = 8'hEE;
    @(posedge clk);
    #1;
    tx_done_i = 1'b0;
    rx_done_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_ready", cmd_ready_o, 1);
    chk("stray_rsp_data", rsp_data_o, last_rsp);

    // Reset in the middle of a LOAD
    base = done_cnt;
    send_cmd(2'd3, 8'h00, 8'h00, 1'b0);
    wait_done(base + 4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_tx.delete();
    exp_rsp.delete();
    last_rsp = 8'h00;
    @(negedge clk);
    check_reset("mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_cmd(2'd1, 8'h01, 8'h02, 1'b0);
    wait_idle();

    // Random commands with a random waveform
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 40; n++) begin
      logic [1:0] t;
      logic [7:0] a;
      logic [7:0] d;
      t = 2'($urandom);
      a = 8'($urandom);
      d = 8'($urandom);
      if (t == 2'd2) begin
        rd_cmd(a, $urandom_range(0, TMO + 4), d);
      end else begin
        send_cmd(t, a, d, 1'b0);
        wait_idle();
      end
    end

    repeat (5) @(negedge clk);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/protocol_encoder.md
# protocol_encoder

Host-side command initiator for the UART register/waveform protocol; the transmitting end of the link whose far side decodes NOP/WR/RD/LOAD byte streams. It accepts one command at a time on a valid/ready port and serialises it into bytes through the UART transmitter using its done handshake. For LOAD it streams a waveform from a synchronous ROM. For RD it waits for the single response byte on the UART receiver, with a timeout.

## Interface
- ADDR_WIDTH, 12: waveform address width.
- DEPTH, 4096: waveform payload bytes per LOAD; must satisfy DEPTH ≤ 2^ADDR_WIDTH and DEPTH ≥ 1.
- RSP_TIMEOUT, 1000000: clk cycles allowed in RSP_WAIT before abort; ≥ 2.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high only in IDLE; the command is accepted on the cycle where cmd_valid_i && cmd_ready_o.
- cmd_type_i  in  2  0=NOP, 1=WR, 2=RD, 3=LOAD.
- cmd_addr_i  in  8  register address for WR/RD.
- cmd_data_i  in  8  register data for WR.
- tx_wr_o  out  1  one-cycle pulse: transmit tx_data_o.
- tx_data_o  out  8  byte to transmit; held stable until the next tx_wr_o.
- tx_done_i  in  1  one-cycle pulse: the UART finished the byte.
- rx_done_i  in  1  one-cycle pulse: a byte was received.
- rx_data_i  in  8  received byte, valid with rx_done_i.
- wave_rd_addr_o  out  ADDR_WIDTH  ROM read address.
- wave_rd_data_i  in  8  ROM data; one-cycle registered latency.
- rsp_valid_o  out  1  one-cycle pulse: RD response is available.
- rsp_data_o  out  8  last RD response; held until the next response.
- rsp_timeout_o  out  1  one-cycle pulse: RD response timed out.
- busy_o  out  1  equals ~cmd_ready_o.

## Operation
- Opcodes on the wire: NOP=8'h00, WR=8'h01, RD=8'h02, LOAD=8'h03.
- Byte sequences:
  - NOP: 00.
  - WR: 01, addr, data.
  - RD: 02, addr, 00. The third byte is a dummy that triggers the far-end response.
  - LOAD: 03, then ROM[0]..ROM[DEPTH-1].
- cmd_type, addr and data are latched at acceptance; cmd_* inputs are don't-care afterwards.
- States:
  - IDLE → TX_BYTE on accept; tx_data_o is loaded with the opcode and the byte index is cleared.
  - TX_BYTE: tx_wr_o=1 for exactly one cycle, then → TX_WAIT.
  - TX_WAIT: on tx_done_i:
    - if bytes remain in a NOP/WR/RD command: load the next byte → TX_BYTE;
    - if in LOAD payload with bytes remaining → FETCH;
    - if the RD command is complete → RSP_WAIT;
    - otherwise → IDLE.
  - FETCH: wave_rd_addr_o holds the payload index. After one cycle, capture wave_rd_data_i into tx_data_o → TX_BYTE. The index is incremented after each payload tx_done_i.
  - RSP_WAIT: timeout counter starts at 0 on entry and increments each cycle.
    - rx_done_i: rsp_data_o ← rx_data_i, rsp_valid_o=1 next cycle → IDLE.
    - Counter reaches RSP_TIMEOUT-1 without rx_done_i: rsp_timeout_o=1 → IDLE.
    - rx_done_i on the same cycle as expiry: the response wins, no timeout pulse.
- Ignored events:
  - rx_done_i outside RSP_WAIT.
  - tx_done_i outside TX_WAIT.
  - cmd_valid_i while busy (not accepted, no side effects).
- Payload index width is ADDR_WIDTH and never wraps within a LOAD. It terminates after index DEPTH-1 is sent. wave_rd_addr_o returns to 0 on entering IDLE.

## Timing
- Reset values: state IDLE, cmd_ready_o=1, busy_o=0, tx_wr_o=0, tx_data_o=0, wave_rd_addr_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_timeout_o=0.
- Accept at cycle N → first tx_wr_o at N+1.
- Register bytes: tx_done_i at cycle T → next tx_wr_o at T+2 (TX_WAIT→TX_BYTE).
- LOAD payload: tx_done_i at T → FETCH at T+1 → tx_wr_o at T+3.
- Last byte tx_done_i at T → cmd_ready_o=1 at T+1 (non-RD).
- RD: rx_done_i at R → rsp_valid_o at R+1, cmd_ready_o at R+1.
- A new command may be accepted in the first cycle cmd_ready_o is high.
- Reset mid-operation: all outputs return immediately to reset values; no partial byte is re-sent after release.

## Test plan
- WR addr 0x12 data 0xA5, tx_done_i returned 5 cycles after each tx_wr_o → tx_data_o sequence 01,12,A5 with exactly 3 tx_wr_o pulses, then cmd_ready_o=1.
- RD addr 0x07, rx_done_i with 0x3C 10 cycles after the last tx_done_i → bytes 02,07,00; rsp_valid_o one cycle with rsp_data_o=0x3C; rsp_timeout_o stays 0.
- RD with RSP_TIMEOUT=16 and no rx_done_i → rsp_timeout_o pulse exactly 16 cycles after RSP_WAIT entry; rsp_data_o unchanged; return to IDLE.
- LOAD with DEPTH=8, ROM[i]=0xF0+i → bytes 03,F0..F7; wave_rd_addr_o steps 0..7; 9 pulses total; each payload tx_wr_o 3 cycles after the preceding tx_done_i.
- NOP, plus cmd_valid_i held high with WR during busy → single byte 00 then the WR accepted afterwards; spurious rx_done_i/tx_done_i in IDLE cause no change.
- Reset asserted after the 3rd LOAD payload byte → outputs at reset values; after release, WR 0x01/0x02 produces exactly 01,01,02.
